// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS pipeline definitions.
//   - word / opcode / immediate widths
//   - conditional-branch opcode constants (beq, bne, blez, bgtz)
//   - branch resolution FSM state type
//   - branch_offset(): sign-extended, word-aligned relative branch offset
// Optional feature macro used by the files that import this package: BRANCH_STATS_EN.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int OP_W   = 6;
    localparam int IMM_W  = 16;

    localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
    localparam logic [OP_W-1:0] OP_BLEZ = 6'b000110;
    localparam logic [OP_W-1:0] OP_BGTZ = 6'b000111;

    typedef enum logic {
        RUN    = 1'b0,
        SHADOW = 1'b1
    } state_t;

    // Immediate counts instructions; the PC works in bytes, hence the <<2.
    function automatic logic [WORD_W-1:0] branch_offset(input logic [IMM_W-1:0] imm);
        return {{(WORD_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: stage-3 branch bundle.
//   master : the pipeline side; drives the decoded instruction (ex_*),
//            receives the redirect (branch, baddr) and squash (flush) outputs.
//   slave  : the branch resolution unit.
// With BRANCH_STATS_EN defined the bundle also carries taken_cnt and
// resolved_cnt (CNT_W bits each) from the slave.
interface branch_ctrl_if #(
    parameter int CNT_W = 16
);
    import mips_pkg::*;

    logic                ex_valid;
    logic [OP_W-1:0]     ex_op;
    logic [IMM_W-1:0]    ex_imm;
    logic [WORD_W-1:0]   ex_rs;
    logic [WORD_W-1:0]   ex_rt;
    logic                branch;
    logic [WORD_W-1:0]   baddr;
    logic                flush;
`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0]    taken_cnt;
    logic [CNT_W-1:0]    resolved_cnt;
`else
    // CNT_W only sizes the optional statistics counters.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

    modport master (
        output ex_valid, ex_op, ex_imm, ex_rs, ex_rt,
        input  branch, baddr, flush
`ifdef BRANCH_STATS_EN
        , input taken_cnt, resolved_cnt
`endif
    );

    modport slave (
        input  ex_valid, ex_op, ex_imm, ex_rs, ex_rt,
        output branch, baddr, flush
`ifdef BRANCH_STATS_EN
        , output taken_cnt, resolved_cnt
`endif
    );

endinterface

// File: rtl/branch_cond.sv
// branch_cond: combinational conditional-branch decode and evaluation.
//   op        in  opcode field
//   rs, rt    in  register operands
//   is_branch out opcode is one of beq/bne/blez/bgtz
//   taken     out branch condition holds (0 for non-branches)
module branch_cond
    import mips_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [WORD_W-1:0] rs,
    input  logic [WORD_W-1:0] rt,
    output logic              is_branch,
    output logic              taken
);

    logic rs_zero;
    logic rs_neg;

    assign rs_zero = (rs == '0);
    assign rs_neg  = rs[WORD_W-1];

    always_comb begin
        is_branch = 1'b1;
        taken     = 1'b0;
        unique case (op)
            OP_BEQ:  taken = (rs == rt);
            OP_BNE:  taken = (rs != rt);
            OP_BLEZ: taken = rs_neg | rs_zero;
            OP_BGTZ: taken = ~rs_neg & ~rs_zero;
            default: is_branch = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: stage-3 branch resolution unit of the 5-stage MIPS pipeline.
//   clk    in  pipeline clock (rising edge)
//   rst_n  in  asynchronous active-low reset
//   bus    branch_ctrl_if.slave:
//            ex_valid/ex_op/ex_imm/ex_rs/ex_rt in  instruction in stage 3
//            branch out  registered one-cycle redirect pulse
//            baddr  out  registered relative byte offset (0 when branch=0)
//            flush  out  registered: the previously presented instruction was squashed
//            taken_cnt/resolved_cnt out  saturating statistics (BRANCH_STATS_EN only)
// Parameters: SHADOW_CYCLES wrong-path slots after a taken branch,
//             CNT_W statistics counter width.
// Optional feature macro: BRANCH_STATS_EN.
module branch_ctrl
    import mips_pkg::*;
#(
    parameter int SHADOW_CYCLES = 3,
    parameter int CNT_W         = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    branch_ctrl_if.slave   bus
);

    localparam int SH_W = (SHADOW_CYCLES < 2) ? 1 : $clog2(SHADOW_CYCLES + 1);

    state_t             state_reg, state_next;
    logic [SH_W-1:0]    cnt_reg, cnt_next;
    logic               branch_reg, branch_next;
    logic [WORD_W-1:0]  baddr_reg, baddr_next;
    logic               flush_reg, flush_next;

    logic               is_branch;
    logic               taken;
    logic               eval_valid;
    logic               take_now;

    branch_cond u_cond (
        .op        (bus.ex_op),
        .rs        (bus.ex_rs),
        .rt        (bus.ex_rt),
        .is_branch (is_branch),
        .taken     (taken)
    );

    // Only RUN evaluates; anything presented during SHADOW is wrong-path.
    assign eval_valid = (state_reg == RUN) && bus.ex_valid && is_branch;
    assign take_now   = eval_valid && taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= RUN;
            cnt_reg    <= '0;
            branch_reg <= 1'b0;
            baddr_reg  <= '0;
            flush_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            branch_reg <= branch_next;
            baddr_reg  <= baddr_next;
            flush_reg  <= flush_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        branch_next = 1'b0;
        baddr_next  = '0;
        flush_next  = 1'b0;
        unique case (state_reg)
            RUN: begin
                if (take_now) begin
                    branch_next = 1'b1;
                    baddr_next  = branch_offset(bus.ex_imm);
                    // With no shadow the redirect needs no squashing at all.
                    if (SHADOW_CYCLES > 0) begin
                        state_next = SHADOW;
                        cnt_next   = SH_W'(SHADOW_CYCLES);
                    end
                end
            end
            SHADOW: begin
                // Bubbles consume a slot too, but there is nothing to squash.
                flush_next = bus.ex_valid;
                cnt_next   = cnt_reg - SH_W'(1);
                if (cnt_reg == SH_W'(1)) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
                cnt_next   = '0;
            end
        endcase
    end

    assign bus.branch = branch_reg;
    assign bus.baddr  = baddr_reg;
    assign bus.flush  = flush_reg;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_cnt_reg, taken_cnt_next;
    logic [CNT_W-1:0] resolved_cnt_reg, resolved_cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_reg    <= '0;
            resolved_cnt_reg <= '0;
        end else begin
            taken_cnt_reg    <= taken_cnt_next;
            resolved_cnt_reg <= resolved_cnt_next;
        end
    end

    // Saturating increments: hold at all-ones rather than wrapping.
    always_comb begin
        taken_cnt_next    = taken_cnt_reg;
        resolved_cnt_next = resolved_cnt_reg;
        if (take_now && !(&taken_cnt_reg)) begin
            taken_cnt_next = taken_cnt_reg + CNT_W'(1);
        end
        if (eval_valid && !(&resolved_cnt_reg)) begin
            resolved_cnt_next = resolved_cnt_reg + CNT_W'(1);
        end
    end

    assign bus.taken_cnt    = taken_cnt_reg;
    assign bus.resolved_cnt = resolved_cnt_reg;
`else
    // CNT_W only sizes the optional statistics counters.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: self-checking bench for branch_ctrl.
// Two instances share the clock and stimulus: u_dut (SHADOW_CYCLES=3) and
// u_dut0 (SHADOW_CYCLES=0). Directed vector table, hand-written reset
// sequence, then randomized stimulus against a behavioural model.
`timescale 1ns/1ps
module tb_branch_ctrl;

    logic clk;
    logic rst_n;

    branch_ctrl_if #(.CNT_W(16)) bif  ();
    branch_ctrl_if #(.CNT_W(16)) bif0 ();

    branch_ctrl #(.SHADOW_CYCLES(3), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    branch_ctrl #(.SHADOW_CYCLES(0), .CNT_W(16)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        valid;
        logic [5:0]  op;
        logic [15:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        exp_branch;
        logic [31:0] exp_baddr;
        logic        exp_flush;
    } vec_t;

    localparam int NVEC = 26;
    vec_t tbl [NVEC];

    // Behavioural model: remaining wrong-path slots per instance, plus stats.
    int model_left [2];
    int model_shadow [2] = '{3, 0};
    int exp_taken;
    int exp_resolved;

    function automatic vec_t mk(input logic v, input logic [5:0] op, input logic [15:0] imm,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic eb, input logic [31:0] ea, input logic ef);
        vec_t r;
        r.valid = v; r.op = op; r.imm = imm; r.rs = rs; r.rt = rt;
        r.exp_branch = eb; r.exp_baddr = ea; r.exp_flush = ef;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Architectural rule of a conditional branch, written with signed ints.
    function automatic void resolve(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                    output bit isb, output bit tk);
        int signed s;
        s = $signed(rs);
        isb = 1'b1;
        tk  = 1'b0;
        case (op)
            6'd4: tk = (rs == rt);
            6'd5: tk = (rs != rt);
            6'd6: tk = (s <= 0);
            6'd7: tk = (s > 0);
            default: isb = 1'b0;
        endcase
    endfunction

    function automatic void model(input int k, input logic v, input logic [5:0] op,
                                  input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                                  output logic eb, output logic [31:0] ea, output logic ef);
        bit isb, tk;
        int signed off;
        eb = 1'b0; ea = 32'h0; ef = 1'b0;
        if (model_left[k] > 0) begin
            ef = v;
            model_left[k] = model_left[k] - 1;
        end else if (v) begin
            resolve(op, rs, rt, isb, tk);
            if (k == 0 && isb) exp_resolved++;
            if (isb && tk) begin
                off = $signed(imm);
                off = off * 4;
                eb = 1'b1;
                ea = off;
                model_left[k] = model_shadow[k];
                if (k == 0) exp_taken++;
            end
        end
    endfunction

    task automatic drive(input logic v, input logic [5:0] op, input logic [15:0] imm,
                         input logic [31:0] rs, input logic [31:0] rt);
        bif.ex_valid = v;  bif.ex_op = op;  bif.ex_imm = imm;  bif.ex_rs = rs;  bif.ex_rt = rt;
        bif0.ex_valid = v; bif0.ex_op = op; bif0.ex_imm = imm; bif0.ex_rs = rs; bif0.ex_rt = rt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_branch", 32'(bif.branch), 32'h0);
        check("rst_baddr", bif.baddr, 32'h0);
        check("rst_flush", 32'(bif.flush), 32'h0);
`ifdef BRANCH_STATS_EN
        check("rst_taken_cnt", 32'(bif.taken_cnt), 32'h0);
        check("rst_resolved_cnt", 32'(bif.resolved_cnt), 32'h0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_left[0] = 0;
        model_left[1] = 0;
        exp_taken = 0;
        exp_resolved = 0;
    endtask

    initial begin
        logic eb, ef, eb0, ef0;
        logic [31:0] ea, ea0;
        logic v;
        logic [5:0] op;
        logic [15:0] imm;
        logic [31:0] rs, rt;

        tbl[0]  = mk(1, 6'd4, 16'h0003, 32'h5, 32'h5, 1, 32'h0000000C, 0);
        tbl[1]  = mk(1, 6'd0, 16'h0000, 32'h0, 32'h0, 0, 32'h0, 1);
        tbl[2]  = mk(1, 6'd0, 16'h0000, 32'h0, 32'h0, 0, 32'h0, 1);
        tbl[3]  = mk(1, 6'd5, 16'h0004, 32'h1, 32'h2, 0, 32'h0, 1);
        tbl[4]  = mk(1, 6'd4, 16'hFFFF, 32'h7, 32'h7, 1, 32'hFFFFFFFC, 0);
        tbl[5]  = mk(0, 6'd4, 16'h0001, 32'h1, 32'h1, 0, 32'h0, 0);
        tbl[6]  = mk(0, 6'd4, 16'h0001, 32'h1, 32'h1, 0, 32'h0, 0);
        tbl[7]  = mk(1, 6'd0, 16'h0000, 32'h0, 32'h0, 0, 32'h0, 1);
        tbl[8]  = mk(1, 6'd0, 16'h0000, 32'h0, 32'h0, 0, 32'h0, 0);
        tbl[9]  = mk(1, 6'd5, 16'h0002, 32'h1, 32'h1, 0, 32'h0, 0);
        tbl[10] = mk(1, 6'd7, 16'hFFFF, 32'hFFFFFFFF, 32'h0, 0, 32'h0, 0);
        tbl[11] = mk(1, 6'd6, 16'hFFFF, 32'hFFFFFFFF, 32'h0, 1, 32'hFFFFFFFC, 0);
        tbl[12] = mk(0, 6'd0, 16'h0000, 32'h0, 32'h0, 0, 32'h0, 0);
        tbl[13] = mk(0, 6'd0, 16'h0000, 32'h0, 32'h0, 0, 32'h0, 0);
        tbl[14] = mk(0, 6'd0, 16'h0000, 32'h0, 32'h0, 0, 32'h0, 0);
        tbl[15] = mk(1, 6'd7, 16'h0010, 32'h1, 32'h0, 1, 32'h00000040, 0);
        tbl[16] = mk(1, 6'd0, 16'h0000, 32'h0, 32'h0, 0, 32'h0, 1);
        tbl[17] = mk(1, 6'd0, 16'h0000, 32'h0, 32'h0, 0, 32'h0, 1);
        tbl[18] = mk(1, 6'd0, 16'h0000, 32'h0, 32'h0, 0, 32'h0, 1);
        tbl[19] = mk(1, 6'd7, 16'h0005, 32'h0, 32'h0, 0, 32'h0, 0);
        tbl[20] = mk(1, 6'd6, 16'h8000, 32'h0, 32'h0, 1, 32'hFFFE0000, 0);
        tbl[21] = mk(0, 6'd0, 16'h0000, 32'h0, 32'h0, 0, 32'h0, 0);
        tbl[22] = mk(0, 6'd0, 16'h0000, 32'h0, 32'h0, 0, 32'h0, 0);
        tbl[23] = mk(0, 6'd0, 16'h0000, 32'h0, 32'h0, 0, 32'h0, 0);
        tbl[24] = mk(1, 6'd3, 16'h0004, 32'h9, 32'h9, 0, 32'h0, 0);
        tbl[25] = mk(1, 6'd4, 16'h0004, 32'h1, 32'h2, 0, 32'h0, 0);

        rst_n = 1'b1;
        drive(0, 6'd0, 16'h0, 32'h0, 32'h0);
        do_reset();

        // Directed table (SHADOW_CYCLES=3 instance; the zero-shadow one must never flush).
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].valid, tbl[i].op, tbl[i].imm, tbl[i].rs, tbl[i].rt);
            check($sformatf("vec%0d_branch", i), 32'(bif.branch), 32'(tbl[i].exp_branch));
            check($sformatf("vec%0d_baddr", i), bif.baddr, tbl[i].exp_baddr);
            check($sformatf("vec%0d_flush", i), 32'(bif.flush), 32'(tbl[i].exp_flush));
            check($sformatf("vec%0d_flush_sh0", i), 32'(bif0.flush), 32'h0);
        end

        // Reset asserted in the 2nd shadow cycle clears outputs without a clock edge.
        drive(1, 6'd4, 16'h0002, 32'h3, 32'h3);
        check("rs_seq_branch", 32'(bif.branch), 32'h1);
        drive(1, 6'd0, 16'h0000, 32'h0, 32'h0);
        check("rs_seq_flush_before", 32'(bif.flush), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_async_flush", 32'(bif.flush), 32'h0);
        check("rs_async_branch", 32'(bif.branch), 32'h0);
        check("rs_async_baddr", bif.baddr, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 6'd4, 16'h0001, 32'h9, 32'h9);
        check("rs_after_branch", 32'(bif.branch), 32'h1);
        check("rs_after_baddr", bif.baddr, 32'h00000004);
        drive(1, 6'd0, 16'h0000, 32'h0, 32'h0);
        check("rs_after_flush", 32'(bif.flush), 32'h1);
        check("rs_after_branch_pulse", 32'(bif.branch), 32'h0);

        // Randomized stimulus against the model, both instances.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            v = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0: op = 6'd4;
                1: op = 6'd5;
                2: op = 6'd6;
                3: op = 6'd7;
                default: op = 6'($urandom);
            endcase
            imm = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rs = 32'h0;
                1: rs = 32'hFFFFFFFF;
                2: rs = $urandom_range(0, 3);
                default: rs = $urandom;
            endcase
            rt = ($urandom_range(0, 1) != 0) ? rs : $urandom;
            model(0, v, op, imm, rs, rt, eb, ea, ef);
            model(1, v, op, imm, rs, rt, eb0, ea0, ef0);
            drive(v, op, imm, rs, rt);
            check($sformatf("rnd%0d_branch", c), 32'(bif.branch), 32'(eb));
            check($sformatf("rnd%0d_baddr", c), bif.baddr, ea);
            check($sformatf("rnd%0d_flush", c), 32'(bif.flush), 32'(ef));
            check($sformatf("rnd%0d_branch_sh0", c), 32'(bif0.branch), 32'(eb0));
            check($sformatf("rnd%0d_baddr_sh0", c), bif0.baddr, ea0);
            check($sformatf("rnd%0d_flush_sh0", c), 32'(bif0.flush), 32'(ef0));
        end
`ifdef BRANCH_STATS_EN
        check("stats_taken_cnt", 32'(bif.taken_cnt), 32'(exp_taken));
        check("stats_resolved_cnt", 32'(bif.resolved_cnt), 32'(exp_resolved));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
